// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences MULT/DIV ops to an external mult/div unit, handles MTHI/MTLO,
// divide-by-zero and timeout; read port stalls while an op is in flight.
module hilo_ctrl #(
  parameter int TIMEOUT_CYC = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic        md_start,
  output logic [1:0]  md_sel,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_done,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        div_zero,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   md_a_q, md_a_d, md_b_q, md_b_d;
  logic [1:0]    md_sel_q, md_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          md_start_q, md_start_d;
  logic          div_zero_q, div_zero_d;
  logic          timeout_err_q, timeout_err_d;
  logic          launch;

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    md_a_d        = md_a_q;
    md_b_d        = md_b_q;
    md_sel_d      = md_sel_q;
    cnt_d         = cnt_q;
    md_start_d    = 1'b0;
    div_zero_d    = 1'b0;
    timeout_err_d = 1'b0;
    launch        = 1'b0;

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op_code)
            3'b000, 3'b001: launch = 1'b1;
            3'b010, 3'b011: begin
              if (op_b == 32'd0) div_zero_d = 1'b1;
              else               launch     = 1'b1;
            end
            3'b100:  hi_d = op_a;
            3'b101:  lo_d = op_a;
            default: ;
          endcase
        end
        if (launch) begin
          state_d    = START;
          md_start_d = 1'b1;
          md_sel_d   = op_code[1:0];
          md_a_d     = op_a;
          md_b_d     = op_b;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A result arriving on the last allowed cycle wins over the timeout.
        if (md_done) begin
          hi_d    = md_hi;
          lo_d    = md_lo;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      md_a_q        <= '0;
      md_b_q        <= '0;
      md_sel_q      <= '0;
      cnt_q         <= '0;
      md_start_q    <= 1'b0;
      div_zero_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      md_a_q        <= md_a_d;
      md_b_q        <= md_b_d;
      md_sel_q      <= md_sel_d;
      cnt_q         <= cnt_d;
      md_start_q    <= md_start_d;
      div_zero_q    <= div_zero_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign op_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign stall       = rd_req && busy;
  assign rd_data     = rd_sel ? hi_q : lo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign md_start    = md_start_q;
  assign md_sel      = md_sel_q;
  assign md_a        = md_a_q;
  assign md_b        = md_b_q;
  assign div_zero    = div_zero_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural mult/div unit, table of ops with a result scoreboard, plus corner sequences.
module tb_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset, op_valid, md_done, rd_req, rd_sel;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b, md_hi, md_lo;
  logic        op_ready, md_start, stall, busy, div_zero, timeout_err;
  logic [1:0]  md_sel;
  logic [31:0] md_a, md_b, rd_data, hi, lo;

  hilo_ctrl #(.TIMEOUT_CYC(40)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .md_start(md_start),
    .md_sel(md_sel), .md_a(md_a), .md_b(md_b), .md_done(md_done),
    .md_hi(md_hi), .md_lo(md_lo), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_data(rd_data), .stall(stall), .hi(hi), .lo(lo), .busy(busy),
    .div_zero(div_zero), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          starts;
    int          dz;
    int          to;
  } exp_t;

  typedef struct {
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   n_start = 0, n_dz = 0, n_to = 0, start_cyc = 0, to_cyc = 0;
  int   md_lat = 32;
  logic md_respond = 1'b1;
  logic inj_tog = 1'b0;
  logic [31:0] inj_hi = '0, inj_lo = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] unit_result(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] ua, ub;
    int         ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (sel)
      2'd0:    return 64'(sa * sb);
      2'd1:    return ua * ub;
      2'd2:    return {32'(ia % ib), 32'(ia / ib)};
      default: return {a % b, a / b};
    endcase
  endfunction

  // Behavioural mult/div unit; also replays injected stray md_done pulses.
  initial begin : md_unit
    logic        inj_seen;
    logic [1:0]  s;
    logic [31:0] a, b;
    inj_seen = 1'b0;
    md_done = 1'b0; md_hi = '0; md_lo = '0;
    forever begin
      @(negedge clk);
      if (inj_tog != inj_seen) begin
        inj_seen = inj_tog;
        md_hi = inj_hi; md_lo = inj_lo; md_done = 1'b1;
        @(negedge clk);
        md_done = 1'b0;
      end else if (md_start && md_respond) begin
        s = md_sel; a = md_a; b = md_b;
        repeat (md_lat) @(negedge clk);
        {md_hi, md_lo} = unit_result(s, a, b);
        md_done = 1'b1;
        @(negedge clk);
        md_done = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (md_start)    begin n_start++; start_cyc = cyc; end
    if (div_zero)    n_dz++;
    if (timeout_err) begin n_to++; to_cyc = cyc; end
  end

  task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    while (busy && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) chk({nm, "_idle_bound"}, 32'(busy), 32'd0);
  endtask

  task automatic do_op(input string nm, input logic [2:0] code, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    int   s0, d0, t0;
    exp_t x;
    sb.push_back(e);
    s0 = n_start; d0 = n_dz; t0 = n_to;
    issue(code, a, b);
    if (e.starts != 0) begin
      chk({nm, "_md_a"}, md_a, a);
      chk({nm, "_md_b"}, md_b, b);
      chk({nm, "_md_sel"}, 32'(md_sel), 32'(code[1:0]));
    end
    wait_idle(nm);
    @(negedge clk);
    x = sb.pop_front();
    chk({nm, "_hi"}, hi, x.hi);
    chk({nm, "_lo"}, lo, x.lo);
    chk({nm, "_starts"}, 32'(n_start - s0), 32'(x.starts));
    chk({nm, "_div_zero"}, 32'(n_dz - d0), 32'(x.dz));
    chk({nm, "_timeout"}, 32'(n_to - t0), 32'(x.to));
    chk({nm, "_op_ready"}, 32'(op_ready), 32'd1);
  endtask

  vec_t vt[11];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end

  initial begin
    int   nb, ns;
    int   s0;
    exp_t e;

    vt[0]  = '{3'b000, 32'hFFFFFFFD, 32'd5, '{32'hFFFFFFFF, 32'hFFFFFFF1, 1, 0, 0}};
    vt[1]  = '{3'b001, 32'hFFFFFFFD, 32'd5, '{32'h00000004, 32'hFFFFFFF1, 1, 0, 0}};
    vt[2]  = '{3'b010, 32'd7,        32'd0, '{32'h00000004, 32'hFFFFFFF1, 0, 1, 0}};
    vt[3]  = '{3'b010, 32'hFFFFFFF9, 32'd2, '{32'hFFFFFFFF, 32'hFFFFFFFD, 1, 0, 0}};
    vt[4]  = '{3'b011, 32'hFFFFFFF9, 32'd2, '{32'h00000001, 32'h7FFFFFFC, 1, 0, 0}};
    vt[5]  = '{3'b100, 32'h12345678, 32'd9, '{32'h12345678, 32'h7FFFFFFC, 0, 0, 0}};
    vt[6]  = '{3'b101, 32'h0000ABCD, 32'd0, '{32'h12345678, 32'h0000ABCD, 0, 0, 0}};
    vt[7]  = '{3'b110, 32'h55555555, 32'd5, '{32'h12345678, 32'h0000ABCD, 0, 0, 0}};
    vt[8]  = '{3'b111, 32'h55555555, 32'd0, '{32'h12345678, 32'h0000ABCD, 0, 0, 0}};
    vt[9]  = '{3'b011, 32'd100,      32'd7, '{32'h00000002, 32'h0000000E, 1, 0, 0}};
    vt[10] = '{3'b011, 32'd3,        32'd0, '{32'h00000002, 32'h0000000E, 0, 1, 0}};

    // Reset with a simultaneous MTHI request: reset must win.
    reset = 1'b1; op_valid = 1'b1; op_code = 3'b100; op_a = 32'hFFFF; op_b = '0;
    rd_req = 1'b1; rd_sel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; op_valid = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_pulses", {29'd0, md_start, div_zero, timeout_err}, 32'd0);
    chk("rst_md_a", md_a, 32'd0);
    chk("rst_md_sel", 32'(md_sel), 32'd0);
    rd_req = 1'b0;

    for (int i = 0; i < 11; i++) do_op($sformatf("vec%0d", i), vt[i].code, vt[i].a, vt[i].b, vt[i].e);

    // Result on the last permitted WAIT cycle beats the timeout.
    md_lat = 40;
    do_op("lat40", 3'b011, 32'd9, 32'd3, '{32'd0, 32'd3, 1, 0, 0});

    // One cycle too late: timeout fires, the late md_done arrives in IDLE and is ignored.
    md_lat = 41;
    do_op("lat41", 3'b011, 32'd20, 32'd3, '{32'd0, 32'd3, 1, 0, 1});
    chk("lat41_to_cycle", 32'(to_cyc - start_cyc), 32'd41);

    md_respond = 1'b0;
    do_op("no_done", 3'b011, 32'd9, 32'd3, '{32'd0, 32'd3, 1, 0, 1});
    chk("no_done_to_cycle", 32'(to_cyc - start_cyc), 32'd41);

    // MFLO stalls across the whole MULT and sees the new LO immediately afterwards.
    md_respond = 1'b1; md_lat = 32;
    rd_req = 1'b1; rd_sel = 1'b0;
    s0 = n_start;
    issue(3'b000, 32'hFFFFFFFD, 32'd5);
    nb = 0; ns = 0;
    while (busy && nb < 400) begin
      nb++;
      if (stall) ns++;
      @(negedge clk);
    end
    chk("mult_busy_cycles", 32'(nb), 32'd33);
    chk("mult_stall_cycles", 32'(ns), 32'd33);
    chk("mult_stall_after", 32'(stall), 32'd0);
    chk("mult_rd_lo", rd_data, 32'hFFFFFFF1);
    rd_sel = 1'b1;
    #1;
    chk("mult_rd_hi", rd_data, 32'hFFFFFFFF);
    chk("mult_starts", 32'(n_start - s0), 32'd1);
    rd_req = 1'b0;

    // MTLO offered during WAIT must be dropped; HI keeps the MTHI value until capture.
    do_op("mthi", 3'b100, 32'h12345678, 32'd0, '{32'h12345678, 32'hFFFFFFF1, 0, 0, 0});
    issue(3'b001, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    op_valid = 1'b1; op_code = 3'b101; op_a = 32'h0000DEAD;
    chk("mtlo_wait_ready", 32'(op_ready), 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    chk("mtlo_wait_hi", hi, 32'h12345678);
    chk("mtlo_wait_lo", lo, 32'hFFFFFFF1);
    wait_idle("multu");
    chk("multu_hi", hi, 32'd0);
    chk("multu_lo", lo, 32'd12);

    // Reset mid-WAIT aborts; a stray md_done three cycles later is ignored.
    md_respond = 1'b0;
    issue(3'b000, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_md_a", md_a, 32'd0);
    @(negedge clk);
    inj_hi = 32'hAAAA5555; inj_lo = 32'h5555AAAA; inj_tog = ~inj_tog;
    repeat (4) @(negedge clk);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_ready", 32'(op_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 40, max WAIT cycles before abort.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: op_valid  in  1  operation request.
REQ-005 SHALL have port: op_code  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
REQ-006 SHALL have ports: op_a, op_b  in  32  rs/rt operands.
REQ-007 SHALL have port: op_ready  out  1  high only in IDLE.
REQ-008 SHALL have port: md_start  out  1  one-cycle start pulse to the mult/div unit.
REQ-009 SHALL have ports: md_sel  out  2 (op_code[1:0]); md_a, md_b  out  32  latched operands.
REQ-010 SHALL have ports: md_done  in  1; md_hi, md_lo  in  32  mult/div result.
REQ-011 SHALL have ports: rd_req  in  1  MFHI/MFLO request; rd_sel  in  1  (1=HI, 0=LO).
REQ-012 SHALL have ports: rd_data  out  32; stall  out  1.
REQ-013 SHALL have ports: hi, lo  out  32  architectural HI/LO.
REQ-014 SHALL have ports: busy, div_zero, timeout_err  out  1.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT; busy = (state != IDLE).
REQ-016 SHALL accept an op only when op_valid && op_ready; op_valid otherwise ignored, no queuing.
REQ-017 MTHI/MTLO accepted at edge N SHALL write op_a to hi/lo, visible cycle N+1; state stays IDLE.
REQ-018 DIV/DIVU with op_b==0 SHALL pulse div_zero for exactly cycle N+1, leave hi/lo unchanged, not assert md_start, stay IDLE.
REQ-019 Other MULT/MULTU/DIV/DIVU SHALL latch md_sel/md_a/md_b at edge N and enter START.
REQ-020 START SHALL last exactly one cycle with md_start=1, then enter WAIT with cycle counter = 0.
REQ-021 md_done SHALL be sampled only in WAIT; ignored in IDLE and START.
REQ-022 md_done in WAIT SHALL load hi<=md_hi, lo<=md_lo at that edge and return to IDLE.
REQ-023 Counter SHALL increment each WAIT cycle without md_done; when it reaches TIMEOUT_CYC, SHALL pulse timeout_err one cycle, return to IDLE, leave hi/lo unchanged.
REQ-024 md_done in the same cycle the counter reaches TIMEOUT_CYC SHALL take priority: capture, no timeout_err.
REQ-025 rd_data SHALL be combinational: rd_sel ? hi : lo.
REQ-026 stall SHALL equal rd_req && busy (combinational).
REQ-027 Once busy clears, stall SHALL drop and rd_data SHALL show the new value.
REQ-028 md_sel/md_a/md_b SHALL hold stable from START through end of WAIT.
REQ-029 Undefined op_codes 110/111 SHALL be accepted and ignored: no state change, no pulses.

Reset
REQ-030 On reset, outputs SHALL be: state IDLE; hi=lo=0; md_a=md_b=0; md_sel=0; counter 0; md_start=div_zero=timeout_err=busy=stall=0; op_ready=1.
REQ-031 Reset SHALL override any simultaneous op_valid or md_done.
REQ-032 Reset mid-START/WAIT SHALL abort the op; a later md_done SHALL be ignored.

Verification
REQ-033 MULT a=0xFFFFFFFD, b=5; model returns md_done 32 cycles after md_start with hi=0xFFFFFFFF, lo=0xFFFFFFF1 -> exactly one md_start pulse, hi/lo captured, busy falls next cycle.
REQ-034 DIV a=7, b=0 -> div_zero high one cycle, md_start never asserted, hi/lo unchanged.
REQ-035 rd_req=1, rd_sel=0 during WAIT -> stall=1 until the cycle after capture; rd_data then equals new lo.
REQ-036 DIVU with md_done never asserted -> timeout_err pulses after 40 WAIT cycles; op_ready returns to 1.
REQ-037 reset asserted mid-WAIT, md_done pulsed 3 cycles later -> hi=lo=0, state IDLE, no capture.
REQ-038 MTHI 0x12345678, then MULTU, then op_valid MTLO during WAIT -> hi=0x12345678 until capture; MTLO ignored.
